dac_mux_arb: RTL
================

DAC_MUX_ARB -- requirements
Module: dac_mux_arb

Interface
REQ-001 The block SHALL have parameter NCH, default 3, giving the number of DAC channels (1..8).
REQ-002 The block SHALL have parameter DW, default 8, giving the DAC code width (8, 10 or 12 for the DAC081/101/121S101 family).
REQ-003 The block SHALL have parameter CLKDIV, default 2, giving the SCLK half-period H in sp_clk cycles (>=1).
REQ-004 The block SHALL have port sp_clk, input, 1, master clock; all logic on its rising edge.
REQ-005 The block SHALL have port sp_rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port wr_data, input, DW, code to load.
REQ-007 The block SHALL have port wr_req, input, NCH, one-cycle write strobe per channel.
REQ-008 The block SHALL have port pend, output, NCH, channel has a queued code.
REQ-009 The block SHALL have port busy, output, 1, frame in progress.
REQ-010 The block SHALL have port done, output, 1, one-cycle frame-complete pulse.
REQ-011 The block SHALL have port done_ch, output, 3, index of the completed channel, valid with done.
REQ-012 The block SHALL have ports dac_sclk, dac_sync_n and dac_din, each output, NCH, per-channel serial interface.
REQ-013 The block SHALL have port rdbk_data, output, NCH*DW, last code sent per channel, channel i at [i*DW +: DW].

Function
REQ-014 On a cycle with wr_req[i]=1, the block SHALL capture wr_data into buffer i and set pend[i] on the next edge; every channel strobed in the same cycle SHALL capture the same wr_data.
REQ-015 A write to a channel whose pend bit is already set SHALL overwrite its buffer (last write wins) and SHALL NOT produce an extra frame.
REQ-016 A write to the channel currently shifting SHALL leave the current frame intact and set pend for a follow-up frame.
REQ-017 The arbiter SHALL grant round-robin, searching from last_grant+1 with wrap-around; after reset last_grant=NCH-1, so the search starts at channel 0.
REQ-018 The FSM SHALL have states IDLE, SETUP, SHIFT and HOLD: IDLE goes to SETUP when any pend is set; SETUP lasts H cycles; SHIFT lasts 16 slots of 2H cycles; HOLD lasts 2H cycles; HOLD returns to IDLE.
REQ-019 The grant SHALL clear pend[g] and copy buffer g into the shift register on the IDLE-to-SETUP edge.
REQ-020 The frame SHALL be 16 bits, MSB first: {2'b00, PD=2'b00, code[DW-1:0], (12-DW) zeros}.
REQ-021 In SETUP, sync_n[g] SHALL be 0, sclk[g] SHALL be 0 and din[g] SHALL be bit 15.
REQ-022 In each SHIFT slot, sclk[g] SHALL be 1 for H cycles and then 0 for H cycles; din SHALL update only on the sclk rising edge, so the DAC samples on the falling edge.
REQ-023 In HOLD, sync_n[g] SHALL be 1 and sclk[g] SHALL be 0.
REQ-024 Unselected channels SHALL drive sclk=0, sync_n=1 and din=0 at all times.
REQ-025 All serial outputs SHALL be registered.
REQ-026 Latency SHALL be as follows: wr_req sampled at edge N -> sync_n low at edge N+2 when IDLE; sync_n low time SHALL be 33H cycles.
REQ-027 busy SHALL be 1 in SETUP, SHIFT and HOLD.
REQ-028 done SHALL pulse on the HOLD-to-IDLE edge, with done_ch=g.
REQ-029 A pend bit still set at the end of HOLD SHALL start the next frame directly from IDLE with no extra idle cycle.

Reset
REQ-030 Asserting sp_rst_n=0 SHALL immediately set the state to IDLE and the outputs to: sync_n all 1, sclk all 0, din all 0, pend 0, busy 0, done 0, done_ch 0, rdbk_data 0, last_grant=NCH-1.
REQ-031 Reset mid-frame SHALL abort the frame with no done pulse and SHALL discard buffered codes.

Configuration
REQ-032 With DAC_MUX_RDBK_EN defined, rdbk_data slice g SHALL update with the sent code on the done edge.
REQ-033 Without DAC_MUX_RDBK_EN, rdbk_data SHALL be constant 0 and no readback registers SHALL be built.

Verification (NCH=3, DW=8, CLKDIV=2)
REQ-034 The bench SHALL apply wr_req=001 with wr_data=8'hA5 and check: sync_n[0] low 2 cycles later for 66 cycles; falling-edge bits 0x0A50; done with done_ch=0 at 70 cycles after sync fall; channels 1 and 2 idle.
REQ-035 The bench SHALL apply wr_req=111 with 8'h3C and check: three 0x03C0 frames on channels 0, 1, 2 in order, back to back; three done pulses.
REQ-036 The bench SHALL, while channel 1 is shifting, strobe channels 0 and 2, and check: next grants are 2 then 0.
REQ-037 The bench SHALL, while channel 0 is shifting, write channel 2 with 8'h11 and then 8'hFF, and check: exactly one channel-2 frame, carrying 0x0FF0.
REQ-038 The bench SHALL reset during SHIFT slot 7 and check: outputs idle in the same cycle, pend=000, no done, and the next write frames correctly.
REQ-039 The bench SHALL, with DAC_MUX_RDBK_EN defined, check rdbk_data[15:8]=8'hA5 after the channel-1 done; without the macro, rdbk_data SHALL stay 0.

Source files
------------

// File: rtl/dac_mux_arb.sv
// Round-robin arbiter that drives NCH serial DACs through one frame engine.
// Define DAC_MUX_RDBK_EN to build per-channel readback of the last code sent.
module dac_mux_arb #(
  parameter int unsigned NCH    = 3,
  parameter int unsigned DW     = 8,
  parameter int unsigned CLKDIV = 2
) (
  input  logic              sp_clk,
  input  logic              sp_rst_n,
  input  logic [DW-1:0]     wr_data,
  input  logic [NCH-1:0]    wr_req,
  output logic [NCH-1:0]    pend,
  output logic              busy,
  output logic              done,
  output logic [2:0]        done_ch,
  output logic [NCH-1:0]    dac_sclk,
  output logic [NCH-1:0]    dac_sync_n,
  output logic [NCH-1:0]    dac_din,
  output logic [NCH*DW-1:0] rdbk_data
);

  localparam int unsigned H  = CLKDIV;
  localparam int unsigned CW = $clog2(2 * H) + 1;
  localparam logic [CW-1:0] HLast    = CW'(H - 1);
  localparam logic [CW-1:0] SlotLast = CW'(2 * H - 1);
  localparam logic [CW-1:0] HCnt     = CW'(H);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

  state_e                 r_state, w_state_d;
  logic [CW-1:0]          r_cnt, w_cnt_d;
  logic [3:0]             r_slot, w_slot_d;
  logic                   w_grant, w_fin, r_fin;
  logic [2:0]             r_gnt, r_last, w_sel;
  logic                   w_found;
  logic [NCH-1:0]         r_pend, w_clr;
  logic [NCH-1:0][DW-1:0] r_buf;
  logic [DW-1:0]          w_code;
  logic [15:0]            r_frame, w_frame;
  logic [NCH-1:0]         w_gnt_oh, w_sclk, w_sync_n, w_din;
  logic [NCH-1:0]         r_sclk, r_sync_n, r_din;
  logic                   r_busy, r_done, w_bit;
  logic [2:0]             r_done_ch;

  // Round-robin search: first pending channel at distance 1..NCH after the last grant.
  always_comb begin
    w_sel   = r_last;
    w_found = 1'b0;
    for (int unsigned d = 1; d <= NCH; d++) begin
      for (int unsigned j = 0; j < NCH; j++) begin
        if (!w_found && r_pend[j] && (j == (32'(r_last) + d) % NCH)) begin
          w_sel   = 3'(j);
          w_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_code = '0;
    for (int unsigned j = 0; j < NCH; j++) begin
      if (w_sel == 3'(j)) w_code = r_buf[j];
    end
  end

  // Frame is {2'b00, PD=2'b00, code, zero pad} so the code is left-aligned at bit 11.
  assign w_frame  = 16'(w_code) << (12 - DW);
  assign w_clr    = w_grant ? (NCH'(1) << w_sel) : '0;
  assign w_gnt_oh = NCH'(1) << r_gnt;
  assign w_bit    = r_frame[4'd15 - r_slot];

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_slot_d  = r_slot;
    w_grant   = 1'b0;
    w_fin     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|r_pend) begin
          w_state_d = StSetup;
          w_cnt_d   = '0;
          w_grant   = 1'b1;
        end
      end
      StSetup: begin
        if (r_cnt == HLast) begin
          w_state_d = StShift;
          w_cnt_d   = '0;
          w_slot_d  = '0;
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      StShift: begin
        if (r_cnt == SlotLast) begin
          w_cnt_d = '0;
          if (r_slot == 4'd15) w_state_d = StHold;
          else                 w_slot_d  = r_slot + 4'd1;
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      StHold: begin
        if (r_cnt == SlotLast) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
          w_fin     = 1'b1;
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Slot k carries bit 15-k; the bit is launched with sclk high and sampled on its fall.
  always_comb begin
    w_sclk   = '0;
    w_sync_n = '1;
    w_din    = '0;
    unique case (r_state)
      StSetup: begin
        w_sync_n = ~w_gnt_oh;
        w_din    = r_frame[15] ? w_gnt_oh : '0;
      end
      StShift: begin
        w_sync_n = ~w_gnt_oh;
        w_sclk   = (r_cnt < HCnt) ? w_gnt_oh : '0;
        w_din    = w_bit ? w_gnt_oh : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sp_clk or negedge sp_rst_n) begin
    if (!sp_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_slot  <= '0;
      r_gnt   <= '0;
      r_last  <= 3'(NCH - 1);
      r_frame <= '0;
      r_pend  <= '0;
      r_buf   <= '0;
      r_fin   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_slot  <= w_slot_d;
      r_fin   <= w_fin;
      // A write on the grant edge re-arms pend for a follow-up frame.
      r_pend  <= (r_pend & ~w_clr) | wr_req;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (wr_req[i]) r_buf[i] <= wr_data;
      end
      if (w_grant) begin
        r_gnt   <= w_sel;
        r_last  <= w_sel;
        r_frame <= w_frame;
      end
    end
  end

  // Output stage: every pin reflects the engine state of the previous cycle.
  always_ff @(posedge sp_clk or negedge sp_rst_n) begin
    if (!sp_rst_n) begin
      r_sclk    <= '0;
      r_sync_n  <= '1;
      r_din     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_ch <= '0;
    end else begin
      r_sclk   <= w_sclk;
      r_sync_n <= w_sync_n;
      r_din    <= w_din;
      r_busy   <= (r_state != StIdle);
      r_done   <= r_fin;
      if (r_fin) r_done_ch <= r_gnt;
    end
  end

`ifdef DAC_MUX_RDBK_EN
  logic [NCH*DW-1:0] r_rdbk;

  always_ff @(posedge sp_clk or negedge sp_rst_n) begin
    if (!sp_rst_n) begin
      r_rdbk <= '0;
    end else if (r_fin) begin
      for (int unsigned j = 0; j < NCH; j++) begin
        if (r_gnt == 3'(j)) r_rdbk[j*DW +: DW] <= r_frame[12-DW +: DW];
      end
    end
  end

  assign rdbk_data = r_rdbk;
`else
  assign rdbk_data = '0;
`endif

  assign pend       = r_pend;
  assign busy       = r_busy;
  assign done       = r_done;
  assign done_ch    = r_done_ch;
  assign dac_sclk   = r_sclk;
  assign dac_sync_n = r_sync_n;
  assign dac_din    = r_din;

endmodule
